// File: rtl/spq_fifo_ctrl_if.sv
// Handshake and single-port RAM bundle for spq_fifo_ctrl.
// The slave modport is the controller side; master is the producer/consumer/RAM environment.
interface spq_fifo_ctrl_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned W  = 108
);
  logic          enq_valid;
  logic          enq_ready;
  logic [W-1:0]  enq_bits;
  logic          deq_valid;
  logic          deq_ready;
  logic [W-1:0]  deq_bits;
  logic [AW+1:0] count;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [W-1:0]  RW0_wmask;
  logic [W-1:0]  RW0_wdata;
  logic [W-1:0]  RW0_rdata;

  modport master (
    output enq_valid, enq_bits, deq_ready, RW0_rdata,
    input  enq_ready, deq_valid, deq_bits, count,
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

  modport slave (
    input  enq_valid, enq_bits, deq_ready, RW0_rdata,
    output enq_ready, deq_valid, deq_bits, count,
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );
endinterface

// File: rtl/spq_fifo_ctrl.sv
// Strict-order FIFO controller over a single-port RAM (1-cycle read) with a 2-entry output buffer.
// Define SPQ_BYPASS_EN to let enqueues skip the RAM when it is empty and nothing is in flight.
module spq_fifo_ctrl #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned W     = 108
) (
  input logic            clock,
  input logic            reset_n,
  spq_fifo_ctrl_if.slave bus
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic [W-1:0]  ob_q [2];
  logic [W-1:0]  ob_d [2];

  logic [1:0]    occ;
  logic          ram_empty, ram_full;
  logic          enq_fire, deq_fire;
  logic          bypass, ram_wr, rd_issue, push;
  logic [W-1:0]  push_data;

  assign occ       = ob_cnt_q + {1'b0, rd_pend_q};
  assign ram_empty = (ram_cnt_q == '0);
  assign ram_full  = (ram_cnt_q == (AW+1)'(DEPTH));

  // Block the producer while the RAM holds data but the buffer is starved, so the read wins.
  assign bus.enq_ready = reset_n && !ram_full && !(!ram_empty && occ == 2'd0);
  assign enq_fire      = bus.enq_valid && bus.enq_ready;

  assign bus.deq_valid = reset_n && (ob_cnt_q != 2'd0);
  assign bus.deq_bits  = ob_q[0];
  assign deq_fire      = bus.deq_valid && bus.deq_ready;

`ifdef SPQ_BYPASS_EN
  logic [1:0] ob_after_pop;
  assign ob_after_pop = ob_cnt_q - {1'b0, deq_fire};
  assign bypass       = enq_fire && ram_empty && !rd_pend_q && (ob_after_pop < 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign ram_wr   = enq_fire && !bypass;
  // A producer held off by enq_ready must not stall reads, so only an actual write blocks one.
  assign rd_issue = reset_n && !ram_empty && (occ < 2'd2) && !ram_wr;

  assign bus.RW0_en    = ram_wr || rd_issue;
  assign bus.RW0_wmode = ram_wr;
  assign bus.RW0_addr  = ram_wr ? wr_ptr_q : rd_ptr_q;
  assign bus.RW0_wdata = bus.enq_bits;
  assign bus.RW0_wmask = '1;

  assign bus.count = reset_n ? ({1'b0, ram_cnt_q} + (AW+2)'(rd_pend_q) + (AW+2)'(ob_cnt_q))
                             : '0;

  assign push      = rd_pend_q || bypass;
  assign push_data = rd_pend_q ? bus.RW0_rdata : bus.enq_bits;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(ram_wr);
    rd_ptr_d  = rd_ptr_q + AW'(rd_issue);
    ram_cnt_d = ram_cnt_q + (AW+1)'(ram_wr) - (AW+1)'(rd_issue);
    rd_pend_d = rd_issue;
    ob_d[0]   = ob_q[0];
    ob_d[1]   = ob_q[1];
    ob_cnt_d  = ob_cnt_q;
    if (deq_fire) begin
      ob_d[0]  = ob_q[1];
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
    // Pop first, then append, so a same-cycle capture lands behind the surviving entry.
    if (push) begin
      if (ob_cnt_d == 2'd0) begin
        ob_d[0] = push_data;
      end else begin
        ob_d[1] = push_data;
      end
      ob_cnt_d = ob_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      ob_cnt_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      ob_cnt_q  <= ob_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    ob_q[0] <= ob_d[0];
    ob_q[1] <= ob_d[1];
  end

endmodule

// File: tb/tb_spq_fifo_ctrl.sv
// Scoreboard bench for spq_fifo_ctrl with a behavioural single-port RAM (registered read address).
module tb_spq_fifo_ctrl;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned W     = 108;
`ifdef SPQ_BYPASS_EN
  localparam int EXP_LAT = 1;
  localparam int EXP_ACC = 0;
`else
  localparam int EXP_LAT = 3;
  localparam int EXP_ACC = 2;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  spq_fifo_ctrl_if #(.AW(AW), .W(W)) bus ();

  spq_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM model: writes land at the edge, reads return mem[addr latched at the issuing edge].
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] raddr_q = '0;
  always @(posedge clock) begin
    if (bus.RW0_en) begin
      if (bus.RW0_wmode) mem[bus.RW0_addr] <= bus.RW0_wdata;
      else               raddr_q <= bus.RW0_addr;
    end
  end
  assign bus.RW0_rdata = mem[raddr_q];

  int checks = 0;
  int passes = 0;
  logic [W-1:0] sb [$];

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Observed RAM traffic: addresses must advance in order and occupancy stay in 0..DEPTH.
  int ram_occ = 0, ram_acc = 0, wr_wraps = 0, rd_wraps = 0;
  logic [AW-1:0] exp_wr = '0, exp_rd = '0, last_wr = '0, last_rd = '0;

  task automatic clear_trackers();
    sb.delete();
    ram_occ = 0;
    exp_wr = '0;
    exp_rd = '0;
    last_wr = '0;
    last_rd = '0;
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.RW0_en) begin
      ram_acc++;
      if (bus.RW0_wmode) begin
        check("ram_wr_addr", bus.RW0_addr, exp_wr);
        check("ram_wr_not_full", ram_occ < DEPTH, 1);
        check("ram_wmask", bus.RW0_wmask, {W{1'b1}});
        if (bus.RW0_addr == '0 && last_wr == AW'(DEPTH - 1)) wr_wraps++;
        last_wr = bus.RW0_addr;
        exp_wr  = exp_wr + 1'b1;
        ram_occ++;
      end else begin
        check("ram_rd_addr", bus.RW0_addr, exp_rd);
        check("ram_rd_not_empty", ram_occ > 0, 1);
        if (bus.RW0_addr == '0 && last_rd == AW'(DEPTH - 1)) rd_wraps++;
        last_rd = bus.RW0_addr;
        exp_rd  = exp_rd + 1'b1;
        ram_occ--;
      end
    end
  end

  // Output monitor: pops the scoreboard on every dequeue handshake.
  always @(negedge clock) begin
    logic [W-1:0] exp_d;
    if (reset_n && bus.deq_valid && bus.deq_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL deq_unexpected: got 0x%0h, expected no dequeue (scoreboard empty)",
                 bus.deq_bits);
      end else begin
        exp_d = sb.pop_front();
        check("deq_bits", bus.deq_bits, exp_d);
      end
    end
  end

  // Called at posedge+1; holds reset across two edges.
  task automatic do_reset();
    reset_n       = 1'b0;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    clear_trackers();
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_deq_valid", bus.deq_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_ram_en", bus.RW0_en, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("enq_ready_after_reset", bus.enq_ready, 1);
    @(posedge clock); #1;
  endtask

  task automatic enq(input logic [W-1:0] d);
    bit fired = 0;
    bus.enq_valid = 1'b1;
    bus.enq_bits  = d;
    for (int i = 0; i < 40 && !fired; i++) begin
      @(negedge clock);
      if (bus.enq_ready) begin
        sb.push_back(d);
        fired = 1;
      end
      @(posedge clock); #1;
    end
    bus.enq_valid = 1'b0;
    check("enq_accept", fired, 1);
  endtask

  task automatic drain();
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
      @(negedge clock);
    end
    check("drain_done", sb.size(), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("drained_count", bus.count, 0);
    check("drained_deq_valid", bus.deq_valid, 0);
    @(posedge clock); #1;
  endtask

  logic [127:0] rnd;
  bit streaming;
  bit found;
  int lat, acc0, dcyc;

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_bits  = '0;
    bus.deq_ready = 1'b0;
    @(posedge clock); #1;
    do_reset();

    // Single enqueue into an empty FIFO: latency and RAM traffic.
    acc0 = ram_acc;
    enq(W'(12'hABC));
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (bus.deq_valid) begin
        lat = k;
        break;
      end
    end
    check("enq_to_deq_latency", lat, EXP_LAT);
    check("latency_deq_bits", bus.deq_bits, 12'hABC);
    check("latency_ram_accesses", ram_acc - acc0, EXP_ACC);
    @(posedge clock); #1;
    drain();

    // Fill to DEPTH+2 with the consumer stalled, push against full, then drain in order.
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 130; i++) enq(W'(i));
    @(negedge clock);
    check("full_count", bus.count, 130);
    check("full_enq_ready", bus.enq_ready, 0);
    @(posedge clock); #1;
    bus.enq_valid = 1'b1;
    bus.enq_bits  = W'(999);
    repeat (5) @(posedge clock);
    #1;
    bus.enq_valid = 1'b0;
    @(negedge clock);
    check("full_count_held", bus.count, 130);
    @(posedge clock); #1;
    drain();

    // Continuous streaming of random words.
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      enq(rnd[W-1:0]);
    end
    drain();

    // Half-rate producer against a slower consumer so the RAM fills and both pointers wrap.
    wr_wraps  = 0;
    rd_wraps  = 0;
    streaming = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          enq(W'(1000 + i));
          @(posedge clock); #1;
        end
        streaming = 0;
      end
      begin
        dcyc = 0;
        while (streaming) begin
          bus.deq_ready = (dcyc % 3 == 0);
          dcyc++;
          @(posedge clock); #1;
        end
      end
    join
    drain();
    check("wr_ptr_wrapped", wr_wraps > 0, 1);
    check("rd_ptr_wrapped", rd_wraps > 0, 1);

    // Reset in the cycle after a read issue: the in-flight data must be dropped.
    bus.deq_ready = 1'b0;
    enq(W'(8'h11));
    enq(W'(8'h22));
    enq(W'(8'h33));
    bus.deq_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.RW0_en && !bus.RW0_wmode) begin
        found = 1;
        break;
      end
    end
    check("rd_issue_seen", found, 1);
    @(posedge clock); #1;
    do_reset();
    @(negedge clock);
    check("post_reset_count", bus.count, 0);
    check("post_reset_deq_valid", bus.deq_valid, 0);
    @(posedge clock); #1;
    enq(W'(4'h5));
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
